// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared types and defaults for the feature window receiver
package cnn_pkg;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_RECV = 2'd1,
    RX_DONE = 2'd2
  } rx_state_e;

  localparam int CNN_IMG_W  = 28;
  localparam int CNN_IMG_H  = 28;
  localparam int CNN_DATA_W = 8;
  localparam int WIN_DIM    = 3;
  localparam int WIN_ELEMS  = WIN_DIM * WIN_DIM;

  // LSB of window element (r,c); r=0 is the oldest row, c=0 the leftmost column
  function automatic int win_lsb(input int r, input int c, input int w);
    return (r * WIN_DIM + c) * w;
  endfunction

endpackage

// File: rtl/feature_line_shift.sv
// rtl/feature_line_shift.sv - DEPTH x DATA_W shift buffer, advances only on shift_en
module feature_line_shift #(
  parameter int DEPTH  = 28,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (shift_en) begin
      mem_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
        mem_d[i] = mem_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Oldest entry is the pixel exactly DEPTH accepted beats ago
  assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/feature_window_rx.sv
// rtl/feature_window_rx.sv - raster feature receiver emitting 3x3 windows; FEATURE_DROP_CNT_EN adds drop_cnt
module feature_window_rx
  import cnn_pkg::*;
#(
  parameter int IMG_W  = CNN_IMG_W,
  parameter int IMG_H  = CNN_IMG_H,
  parameter int DATA_W = CNN_DATA_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          feature_valid,
  input  logic [DATA_W-1:0]             feature_in,
  output logic                          hold_data,
  output logic                          win_valid,
  output logic [WIN_ELEMS*DATA_W-1:0]   win_data,
  output logic                          frame_done
`ifdef FEATURE_DROP_CNT_EN
  ,
  output logic [7:0]                    drop_cnt
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  localparam logic [1:0] ST_IDLE = RX_IDLE;
  localparam logic [1:0] ST_RECV = RX_RECV;
  localparam logic [1:0] ST_DONE = RX_DONE;

  logic [1:0]                  state_q, state_d;
  logic [CW-1:0]               col_q, col_d;
  logic [RW-1:0]               row_q, row_d;
  logic                        hold_q, hold_d;
  logic                        win_valid_q, win_valid_d;
  logic [WIN_ELEMS*DATA_W-1:0] win_data_q, win_data_d;
  logic [DATA_W-1:0]           tap_q [WIN_DIM][WIN_DIM];
  logic [DATA_W-1:0]           tap_d [WIN_DIM][WIN_DIM];
  logic [DATA_W-1:0]           lb1_dout, lb2_dout;
  logic                        accept, last_pix;

  assign accept   = feature_valid && (state_q != ST_DONE);
  assign last_pix = (row_q == RW'(IMG_H-1)) && (col_q == CW'(IMG_W-1));

  feature_line_shift #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_row1 (
    .clk      (clk),
    .rst      (rst),
    .shift_en (accept),
    .din      (feature_in),
    .dout     (lb1_dout)
  );

  feature_line_shift #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_row2 (
    .clk      (clk),
    .rst      (rst),
    .shift_en (accept),
    .din      (lb1_dout),
    .dout     (lb2_dout)
  );

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    hold_d      = hold_q;
    tap_d       = tap_q;
    win_valid_d = 1'b0;
    win_data_d  = win_data_q;
    if (accept) begin
      // Column taps slide left; the new column is (row-2, row-1, current) at c=2
      for (int r = 0; r < WIN_DIM; r++) begin
        tap_d[r][0] = tap_q[r][1];
        tap_d[r][1] = tap_q[r][2];
      end
      tap_d[0][2] = lb2_dout;
      tap_d[1][2] = lb1_dout;
      tap_d[2][2] = feature_in;
      win_valid_d = (row_q >= RW'(2)) && (col_q >= CW'(2));
      if (last_pix) begin
        state_d = ST_DONE;
        hold_d  = 1'b1;
        col_d   = '0;
        row_d   = '0;
      end else begin
        state_d = ST_RECV;
        if (col_q == CW'(IMG_W-1)) begin
          col_d = '0;
          row_d = row_q + RW'(1);
        end else begin
          col_d = col_q + CW'(1);
        end
      end
    end
    if (win_valid_d) begin
      for (int r = 0; r < WIN_DIM; r++) begin
        for (int c = 0; c < WIN_DIM; c++) begin
          win_data_d[win_lsb(r, c, DATA_W) +: DATA_W] = tap_d[r][c];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      hold_q      <= 1'b0;
      win_valid_q <= 1'b0;
      win_data_q  <= '0;
      for (int r = 0; r < WIN_DIM; r++) begin
        for (int c = 0; c < WIN_DIM; c++) begin
          tap_q[r][c] <= '0;
        end
      end
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      hold_q      <= hold_d;
      win_valid_q <= win_valid_d;
      win_data_q  <= win_data_d;
      tap_q       <= tap_d;
    end
  end

  assign hold_data  = hold_q;
  assign win_valid  = win_valid_q;
  assign win_data   = win_data_q;
  assign frame_done = (state_q == ST_DONE);

`ifdef FEATURE_DROP_CNT_EN
  logic [7:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (feature_valid && (state_q == ST_DONE) && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_q <= 8'd0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_feature_window_rx.sv
// tb/tb_feature_window_rx.sv - randomized model-checked bench for feature_window_rx
module tb_feature_window_rx;

  localparam int W = 5;
  localparam int H = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fv = 1'b0;
  logic [7:0]  fin = 8'd0;
  logic        hold, wv, fd;
  logic [71:0] wd;
  logic        fv2 = 1'b0;
  logic [7:0]  fin2 = 8'd0;
  logic        hold2, wv2, fd2;
  logic [71:0] wd2;
`ifdef FEATURE_DROP_CNT_EN
  logic [7:0]  drop, drop2;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  feature_window_rx #(.IMG_W(W), .IMG_H(H), .DATA_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .feature_valid (fv),
    .feature_in    (fin),
    .hold_data     (hold),
    .win_valid     (wv),
    .win_data      (wd),
    .frame_done    (fd)
`ifdef FEATURE_DROP_CNT_EN
    ,
    .drop_cnt      (drop)
`endif
  );

  feature_window_rx dut2 (
    .clk           (clk),
    .rst           (rst),
    .feature_valid (fv2),
    .feature_in    (fin2),
    .hold_data     (hold2),
    .win_valid     (wv2),
    .win_data      (wd2),
    .frame_done    (fd2)
`ifdef FEATURE_DROP_CNT_EN
    ,
    .drop_cnt      (drop2)
`endif
  );

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Window whose top-left pixel has raster index tl, pixel value = index mod 256
  function automatic logic [71:0] mkwin(input int tl, input int w);
    logic [71:0] v;
    v = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        v[(r*3+c)*8 +: 8] = 8'(tl + r*w + c);
    return v;
  endfunction

  // Reference: frame kept as an array of accepted pixels in arrival order
  logic [7:0]  pix [W*H];
  int          m_cnt = 0;
  int          m_drop = 0;
  logic        m_done = 1'b0;
  logic        m_valid = 1'b0;
  logic [71:0] m_data = '0;

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_cnt = 0; m_drop = 0; m_done = 1'b0; m_valid = 1'b0; m_data = '0;
      end else begin
        m_valid = 1'b0;
        if (fv) begin
          if (m_done) begin
            if (m_drop < 255) m_drop++;
          end else begin
            int r, c;
            pix[m_cnt] = fin;
            r = m_cnt / W;
            c = m_cnt % W;
            if (r >= 2 && c >= 2) begin
              m_valid = 1'b1;
              for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                  m_data[(i*3+j)*8 +: 8] = pix[(r-2+i)*W + c-2+j];
            end
            if (m_cnt == W*H-1) m_done = 1'b1;
            m_cnt++;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("win_valid", {71'd0, wv}, {71'd0, m_valid});
      chk("win_data", wd, m_data);
      chk("hold_data", {71'd0, hold}, {71'd0, m_done});
      chk("frame_done", {71'd0, fd}, {71'd0, m_done});
`ifdef FEATURE_DROP_CNT_EN
      chk("drop_cnt", {64'd0, drop}, 72'(m_drop));
`endif
    end
  end

  logic [71:0] win_log [$];
  int          n2 = 0;
  logic [71:0] last2 = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (wv) win_log.push_back(wd);
      if (wv2) begin
        n2++;
        last2 = wd2;
      end
    end
  end

  task automatic beat(input logic [7:0] v);
    fv = 1'b1;
    fin = v;
    @(negedge clk);
  endtask

  task automatic gap(input int n);
    fv = 1'b0;
    repeat (n) begin
      fin = 8'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    fv = 1'b0;
    fv2 = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_win_valid", {71'd0, wv}, 72'd0);
    chk("rst_win_data", wd, 72'd0);
    chk("rst_hold", {71'd0, hold}, 72'd0);
    chk("rst_frame_done", {71'd0, fd}, 72'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic check_frame(input string nm, input int n0);
    #1;
    chk({nm, "_count"}, 72'(win_log.size() - n0), 72'd9);
    if (win_log.size() - n0 == 9) begin
      chk({nm, "_first"}, win_log[n0], mkwin(0, W));
      chk({nm, "_last"}, win_log[n0+8], mkwin(12, W));
    end
    chk({nm, "_hold"}, {71'd0, hold}, 72'd1);
  endtask

  initial begin
    int n0, s2;
    repeat (3) @(negedge clk);
    chk("init_win_valid", {71'd0, wv}, 72'd0);
    chk("init_hold", {71'd0, hold}, 72'd0);
    rst = 1'b1;

    // Back-to-back 0..24 with per-beat window timing pinned by position
    n0 = win_log.size();
    for (int k = 0; k < W*H; k++) begin
      beat(8'(k));
      if (k >= 10) chk("pos_win_valid", {71'd0, wv}, {71'd0, (k % W) >= 2});
      if (k == 23) chk("pre_last_hold", {71'd0, hold}, 72'd0);
    end
    check_frame("seq", n0);
    beat(8'd25);
    beat(8'd26);
    gap(1);
    #1;
    chk("drop_count", 72'(win_log.size() - n0), 72'd9);
    chk("drop_hold", {71'd0, hold}, 72'd1);
    chk("drop_frame_done", {71'd0, fd}, 72'd1);
`ifdef FEATURE_DROP_CNT_EN
    chk("drop_cnt_lit", {64'd0, drop}, 72'd2);
`endif

    // Same stream with random idle gaps
    do_reset();
    n0 = win_log.size();
    for (int k = 0; k < W*H; k++) begin
      beat(8'(k));
      if ($urandom_range(0, 1) == 1) gap($urandom_range(1, 3));
    end
    gap(1);
    check_frame("gaps", n0);

    // Reset after 13 beats, then a full resend
    do_reset();
    for (int k = 0; k < 13; k++) beat(8'(k));
    do_reset();
    n0 = win_log.size();
    for (int k = 0; k < W*H; k++) beat(8'(k));
    check_frame("midrst", n0);

    // Random data and gaps, with trailing drops
    for (int f = 0; f < 4; f++) begin
      do_reset();
      for (int k = 0; k < W*H; k++) begin
        beat(8'($urandom));
        if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 3));
      end
      for (int d = 0; d < int'($urandom_range(1, 3)); d++) beat(8'($urandom));
      gap(2);
    end

    // Default 28x28 frame on the second instance
    do_reset();
    s2 = n2;
    for (int k = 0; k < 784; k++) begin
      fv2 = 1'b1;
      fin2 = 8'(k);
      @(negedge clk);
      if (k == 782) chk("big_hold_before", {71'd0, hold2}, 72'd0);
      if (k == 783) chk("big_hold_after", {71'd0, hold2}, 72'd1);
    end
    fv2 = 1'b0;
    @(negedge clk);
    #1;
    chk("big_count", 72'(n2 - s2), 72'd676);
    chk("big_last", last2, mkwin(25*28 + 25, 28));
    chk("big_frame_done", {71'd0, fd2}, 72'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
